// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: double-banked coefficient loader that swaps a shadow bank into the FIR on a sample boundary.
// Optional build macro FIR_CTRL_READBACK_EN adds a combinational active-bank readback port (rd_addr/rd_data).
module fir_coeff_ctrl #(
    parameter int N = 16,
    parameter int T = 51
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic signed [N-1:0]  cfg_data,
    input  logic                 cfg_last,
    input  logic                 sample_strobe,
    output logic [T*N-1:0]       coeff_flat,
    output logic                 bank_sel,
    output logic                 flt_valid,
    output logic                 busy,
    output logic                 cfg_err,
    output logic [1:0]           state_dbg
`ifdef FIR_CTRL_READBACK_EN
    ,
    input  logic [$clog2(T)-1:0] rd_addr,
    output logic [N-1:0]         rd_data
`endif
);

    localparam int IW = $clog2(T);
    localparam logic [IW-1:0] IDX_LAST  = IW'(T - 1);
    localparam logic [IW-1:0] FLUSH_END = IW'(T - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e          state, state_d;
    logic [IW-1:0]   idx, idx_d;
    logic [IW-1:0]   flush_cnt, flush_d;
    logic [IW-1:0]   wr_idx;
    logic            bank_sel_d;
    logic            loaded, loaded_d;
    logic            err_d;
    logic            wr_en;
    logic            fire;
    logic [T*N-1:0]  bank [2];

    // Handshake: a word transfers on a rising edge where cfg_valid && cfg_ready;
    // cfg_ready depends only on state, and words offered while it is low stay with the sender.
    assign cfg_ready  = (state == IDLE) || (state == LOAD);
    assign fire       = cfg_valid && cfg_ready;
    assign busy       = (state != IDLE);
    assign state_dbg  = state;
    assign coeff_flat = bank[bank_sel];

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        flush_d    = flush_cnt;
        bank_sel_d = bank_sel;
        loaded_d   = loaded;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = idx;
        case (state)
            IDLE: begin
                if (fire) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    idx_d  = IW'(1);
                    if (cfg_last) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (fire) begin
                    wr_en = 1'b1;
                    idx_d = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        if (cfg_last) begin
                            state_d = ARMED;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                        idx_d = '0;
                    end else if (cfg_last) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            ARMED: begin
                if (sample_strobe) begin
                    bank_sel_d = ~bank_sel;
                    loaded_d   = 1'b1;
                    flush_d    = '0;
                    state_d    = FLUSH;
                end
            end
            FLUSH: begin
                // The swap strobe plus T-1 further strobes cover the whole delay line.
                if (sample_strobe) begin
                    flush_d = flush_cnt + 1'b1;
                    if (flush_cnt == FLUSH_END) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            flush_cnt <= '0;
            bank_sel  <= 1'b0;
            loaded    <= 1'b0;
            cfg_err   <= 1'b0;
            flt_valid <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            flush_cnt <= flush_d;
            bank_sel  <= bank_sel_d;
            loaded    <= loaded_d;
            cfg_err   <= err_d;
            flt_valid <= sample_strobe && loaded && (state != FLUSH);
        end
    end

    // Only the shadow bank is ever written, so the FIR never sees a partial set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank[0] <= '0;
            bank[1] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < T; k++) begin
                if (wr_idx == IW'(k)) begin
                    bank[~bank_sel][k*N +: N] <= cfg_data;
                end
            end
        end
    end

`ifdef FIR_CTRL_READBACK_EN
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < T; k++) begin
            if (rd_addr == IW'(k)) begin
                rd_data = coeff_flat[k*N +: N];
            end
        end
    end
`endif

endmodule
